// File: rtl/rs5_plic.sv
// rs5_plic: single-context (hart 0, M-mode) platform-level interrupt controller
// with memory-mapped priority, pending, enable, threshold and claim/complete
// registers. Sources are numbered 1..i_cnt; ID 0 means "no interrupt".
module rs5_plic #(
   parameter int unsigned i_cnt = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en_i,
   input  logic [3:0]       we_i,
   input  logic [23:0]      addr_i,
   input  logic [31:0]      data_i,
   output logic [31:0]      data_o,
   input  logic [i_cnt:1]   irq_i,
   input  logic             iack_i,
   output logic [i_cnt:1]   iack_o,
   output logic             irq_o
);

   localparam int unsigned IdW   = 5;
   localparam int unsigned PrioW = 3;
   localparam int unsigned WordW = 22;
   localparam int unsigned DataW = 32;

   // Word addresses (byte address >> 2)
   localparam logic [WordW-1:0] PendWord  = 22'h000400;  // 0x001000
   localparam logic [WordW-1:0] EnWord    = 22'h000800;  // 0x002000
   localparam logic [WordW-1:0] ThrWord   = 22'h080000;  // 0x200000
   localparam logic [WordW-1:0] ClaimWord = 22'h080001;  // 0x200004

   // State
   logic [PrioW-1:0] prio_q [1:i_cnt];
   logic [PrioW-1:0] prio_d [1:i_cnt];
   logic [i_cnt:1]   enable_q,   enable_d;
   logic [i_cnt:1]   pending_q,  pending_d;
   logic [i_cnt:1]   inflight_q, inflight_d;
   logic [PrioW-1:0] thresh_q,   thresh_d;
   logic [IdW-1:0]   snap_id_q,  snap_id_d;
   logic             snap_valid_q, snap_valid_d;
   logic [DataW-1:0] data_q,     data_d;
   logic [i_cnt:1]   iack_q,     iack_d;
   logic             irq_q,      irq_d;

   // Combinational helpers
   logic [WordW-1:0] word_c;
   logic             rd_c;
   logic             wr_c;
   logic [DataW-1:0] mask_c;
   logic [DataW-1:0] cmp_val_c;
   logic [IdW-1:0]   max_id_c;
   logic [PrioW-1:0] max_pr_c;
   logic [IdW-1:0]   claim_id_c;
   logic [DataW-1:0] rdata_c;
   logic             unused_addr_c;

   assign word_c        = addr_i[23:2];
   assign rd_c          = en_i && (we_i == 4'b0000);
   assign wr_c          = en_i && (we_i != 4'b0000);
   assign mask_c        = {{8{we_i[3]}}, {8{we_i[2]}}, {8{we_i[1]}}, {8{we_i[0]}}};
   assign cmp_val_c     = data_i & mask_c;
   assign claim_id_c    = snap_valid_q ? snap_id_q : max_id_c;
   assign unused_addr_c = ^addr_i[1:0];

   // Arbitration: highest priority among pending & enabled, ties to lowest ID,
   // priority 0 never wins because the comparison is strict against 0.
   always_comb begin
      max_id_c = '0;
      max_pr_c = '0;
      for (int unsigned k = 1; k <= i_cnt; k++) begin
         if (pending_q[k] && enable_q[k] && (prio_q[k] > max_pr_c)) begin
            max_pr_c = prio_q[k];
            max_id_c = IdW'(k);
         end
      end
   end

   // Read mux for every register except claim, zero-extended to 32 bits
   always_comb begin
      rdata_c = '0;
      for (int unsigned k = 1; k <= i_cnt; k++) begin
         if (word_c == WordW'(k)) begin
            rdata_c = DataW'(prio_q[k]);
         end
      end
      if (word_c == PendWord) begin
         for (int unsigned k = 1; k <= i_cnt; k++) begin
            rdata_c[k] = pending_q[k];
         end
      end
      if (word_c == EnWord) begin
         for (int unsigned k = 1; k <= i_cnt; k++) begin
            rdata_c[k] = enable_q[k];
         end
      end
      if (word_c == ThrWord) begin
         rdata_c = DataW'(thresh_q);
      end
   end

   // Next-state: gateway, snapshot, claim/complete, register writes, outputs
   always_comb begin
      prio_d       = prio_q;
      enable_d     = enable_q;
      thresh_d     = thresh_q;
      inflight_d   = inflight_q;
      pending_d    = pending_q | (irq_i & ~inflight_q);
      snap_id_d    = snap_id_q;
      snap_valid_d = snap_valid_q;
      data_d       = data_q;
      iack_d       = '0;
      irq_d        = (max_id_c != '0) && (max_pr_c > thresh_q) && !snap_valid_q;

      if (iack_i) begin
         snap_id_d    = max_id_c;
         snap_valid_d = 1'b1;
      end

      if (rd_c) begin
         if (word_c == ClaimWord) begin
            // A claim in the same cycle as iack_i discards the new snapshot
            data_d       = DataW'(claim_id_c);
            snap_id_d    = snap_id_q;
            snap_valid_d = 1'b0;
            for (int unsigned k = 1; k <= i_cnt; k++) begin
               if (claim_id_c == IdW'(k)) begin
                  pending_d[k]  = 1'b0;
                  inflight_d[k] = 1'b1;
                  iack_d[k]     = 1'b1;
               end
            end
         end else begin
            data_d = rdata_c;
         end
      end

      if (wr_c) begin
         for (int unsigned k = 1; k <= i_cnt; k++) begin
            if ((word_c == WordW'(k)) && we_i[0]) begin
               prio_d[k] = data_i[PrioW-1:0];
            end
         end
         if (word_c == EnWord) begin
            for (int unsigned k = 1; k <= i_cnt; k++) begin
               if (we_i[k/8]) begin
                  enable_d[k] = data_i[k];
               end
            end
         end
         if ((word_c == ThrWord) && we_i[0]) begin
            thresh_d = data_i[PrioW-1:0];
         end
         if (word_c == ClaimWord) begin
            // Completing an ID that is not in flight is a no-op
            for (int unsigned k = 1; k <= i_cnt; k++) begin
               if (cmp_val_c == DataW'(k)) begin
                  inflight_d[k] = 1'b0;
               end
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 1; k <= i_cnt; k++) begin
            prio_q[k] <= '0;
         end
         enable_q     <= '0;
         pending_q    <= '0;
         inflight_q   <= '0;
         thresh_q     <= '0;
         snap_id_q    <= '0;
         snap_valid_q <= 1'b0;
         data_q       <= '0;
         iack_q       <= '0;
         irq_q        <= 1'b0;
      end else begin
         prio_q       <= prio_d;
         enable_q     <= enable_d;
         pending_q    <= pending_d;
         inflight_q   <= inflight_d;
         thresh_q     <= thresh_d;
         snap_id_q    <= snap_id_d;
         snap_valid_q <= snap_valid_d;
         data_q       <= data_d;
         iack_q       <= iack_d;
         irq_q        <= irq_d;
      end
   end

   assign data_o = data_q;
   assign iack_o = iack_q;
   assign irq_o  = irq_q;

endmodule

// File: tb/tb_rs5_plic.sv
// tb_rs5_plic: directed and random bus/interrupt stimulus against a behavioural
// PLIC model; expected outputs are queued per cycle and checked by a monitor.
module tb_rs5_plic;

   localparam int unsigned N = 3;

   localparam logic [23:0] A_PRIO1 = 24'h000004;
   localparam logic [23:0] A_PRIO2 = 24'h000008;
   localparam logic [23:0] A_PRIO3 = 24'h00000C;
   localparam logic [23:0] A_PEND  = 24'h001000;
   localparam logic [23:0] A_EN    = 24'h002000;
   localparam logic [23:0] A_THR   = 24'h200000;
   localparam logic [23:0] A_CLAIM = 24'h200004;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          en_i;
   logic [3:0]    we_i;
   logic [23:0]   addr_i;
   logic [31:0]   data_i;
   logic [31:0]   data_o;
   logic [N:1]    irq_i;
   logic          iack_i;
   logic [N:1]    iack_o;
   logic          irq_o;

   rs5_plic #(.i_cnt(N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (en_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .data_i  (data_i),
      .data_o  (data_o),
      .irq_i   (irq_i),
      .iack_i  (iack_i),
      .iack_o  (iack_o),
      .irq_o   (irq_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        irq;
      logic [N:1]  iack;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q [$];
   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   // Reference model state
   bit [2:0]    m_prio [1:N];
   bit [N:1]    m_en;
   bit [N:1]    m_pend;
   bit [N:1]    m_inf;
   bit [2:0]    m_thr;
   int unsigned m_snap;
   bit          m_snapv;
   bit [31:0]   m_data;

   // Winner: scan priorities from 7 down, first (lowest) ID at that level wins
   function automatic int unsigned model_max_id();
      for (int p = 7; p >= 1; p--) begin
         for (int unsigned k = 1; k <= N; k++) begin
            if (m_pend[k] && m_en[k] && (int'(m_prio[k]) == p)) return k;
         end
      end
      return 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
      end
   endtask

   // Reference model: advances on each rising edge and queues expected outputs
   always @(posedge clk) begin
      exp_t        e;
      int unsigned mid;
      int unsigned word;
      int unsigned cid;
      int unsigned val;
      bit [N:1]    pend_n;
      bit [31:0]   mask;
      bit [31:0]   rd;
      bit          is_claim_rd;
      e = '0;
      if (!reset_n) begin
         for (int unsigned k = 1; k <= N; k++) m_prio[k] = '0;
         m_en = '0; m_pend = '0; m_inf = '0; m_thr = '0;
         m_snap = 0; m_snapv = 1'b0; m_data = '0;
      end else begin
         mid   = model_max_id();
         word  = 32'(addr_i[23:2]);
         e.irq = (mid != 0) && (m_prio[mid] > m_thr) && !m_snapv;
         for (int unsigned k = 1; k <= N; k++) begin
            pend_n[k] = m_pend[k] || (irq_i[k] && !m_inf[k]);
         end
         for (int b = 0; b < 4; b++) mask[b*8 +: 8] = we_i[b] ? 8'hFF : 8'h00;
         is_claim_rd = en_i && (we_i == 4'b0000) && (word == 32'h80001);
         if (en_i && (we_i == 4'b0000)) begin
            rd = '0;
            if (word >= 1 && word <= N) rd = 32'(m_prio[word]);
            else if (word == 32'h400) begin
               for (int unsigned k = 1; k <= N; k++) rd[k] = m_pend[k];
            end else if (word == 32'h800) begin
               for (int unsigned k = 1; k <= N; k++) rd[k] = m_en[k];
            end else if (word == 32'h80000) rd = 32'(m_thr);
            else if (is_claim_rd) begin
               cid = m_snapv ? m_snap : mid;
               rd  = cid;
               m_snapv = 1'b0;
               if (cid != 0) begin
                  pend_n[cid] = 1'b0;
                  m_inf[cid]  = 1'b1;
                  e.iack[cid] = 1'b1;
               end
            end
            m_data = rd;
         end
         if (iack_i && !is_claim_rd) begin
            m_snap  = mid;
            m_snapv = 1'b1;
         end
         if (en_i && (we_i != 4'b0000)) begin
            if (word >= 1 && word <= N && we_i[0]) m_prio[word] = data_i[2:0];
            if (word == 32'h800) begin
               for (int unsigned k = 1; k <= N; k++) if (we_i[k/8]) m_en[k] = data_i[k];
            end
            if (word == 32'h80000 && we_i[0]) m_thr = data_i[2:0];
            if (word == 32'h80001) begin
               val = data_i & mask;
               if (val >= 1 && val <= N && m_inf[val]) m_inf[val] = 1'b0;
            end
         end
         m_pend = pend_n;
      end
      e.data = m_data;
      exp_q.push_back(e);
   end

   // Monitor: one queued expectation per cycle; reset forces all-zero outputs
   always @(negedge clk) begin
      exp_t e;
      bit   have;
      have = (exp_q.size() != 0);
      e    = '0;
      if (have) e = exp_q.pop_front();
      if (!reset_n) begin
         e = '0;
      end else if (!have) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_underflow at %0t: got empty queue, expected an entry", $time);
      end
      chk("irq_o",  32'(irq_o),  32'(e.irq));
      chk("iack_o", 32'(iack_o), 32'(e.iack));
      chk("data_o", data_o,      e.data);
   end

   task automatic step(input logic e, input logic [3:0] w, input logic [23:0] a,
                       input logic [31:0] d);
      en_i = e; we_i = w; addr_i = a; data_i = d;
      @(posedge clk);
      #1;
      en_i = 1'b0; we_i = 4'b0000; iack_i = 1'b0;
   endtask

   task automatic wr(input logic [23:0] a, input logic [31:0] d);
      step(1'b1, 4'hF, a, d);
   endtask

   task automatic rd(input logic [23:0] a);
      step(1'b1, 4'h0, a, 32'h0);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, 4'h0, 24'h0, 32'h0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle(2);
      reset_n = 1'b1;
   endtask

   logic [23:0] addr_tab [10];

   initial begin
      addr_tab = '{A_PRIO1, A_PRIO2, A_PRIO3, A_PEND, A_EN, A_THR, A_CLAIM,
                   24'h000000, 24'h000010, 24'h001004};
      reset_n = 1'b0; en_i = 1'b0; we_i = '0; addr_i = '0; data_i = '0;
      irq_i = '0; iack_i = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;

      // Reset values through the bus
      rd(A_PEND); rd(A_EN); rd(A_CLAIM);

      // Single source: pend, raise irq, claim
      wr(A_PRIO1, 3); wr(A_EN, 32'h2); wr(A_THR, 0);
      irq_i = 3'b001; idle(3);
      rd(A_PEND); rd(A_CLAIM); idle(2); rd(A_PEND);
      irq_i = 3'b000; wr(A_CLAIM, 1); idle(1);

      // Threshold is a strict comparison
      wr(A_THR, 3); irq_i = 3'b001; idle(4);
      wr(A_THR, 2); idle(3);
      rd(A_CLAIM); irq_i = 3'b000; wr(A_CLAIM, 1); idle(2);

      // Equal priorities: lowest ID first, then the other after complete
      wr(A_PRIO2, 5); wr(A_PRIO3, 5); wr(A_EN, 32'hE);
      irq_i = 3'b110; idle(3);
      rd(A_CLAIM); wr(A_CLAIM, 2); rd(A_CLAIM);
      wr(A_CLAIM, 3); idle(2);

      // Snapshot masks irq and survives a later higher-priority source
      iack_i = 1'b1; idle(1); idle(2);
      wr(A_PRIO1, 7); irq_i = 3'b111; idle(3);
      rd(A_CLAIM); idle(2);

      // Claim together with iack: snapshot discarded
      iack_i = 1'b1; rd(A_CLAIM); idle(2); rd(A_CLAIM);

      // Held request stays quiet until the matching complete
      idle(3); rd(A_PEND);
      wr(A_CLAIM, 0); wr(A_CLAIM, 5); idle(2); rd(A_PEND);
      wr(A_CLAIM, 1); wr(A_CLAIM, 2); wr(A_CLAIM, 3); idle(3); rd(A_PEND);
      rd(A_CLAIM); idle(2);

      // Randomized traffic with one asynchronous reset mid-run
      for (int i = 0; i < 1500; i++) begin
         int unsigned op;
         logic [23:0] a;
         logic [3:0]  w;
         logic [31:0] d;
         if (i == 750) do_reset();
         if ($urandom_range(0, 7) == 0) irq_i = N'($urandom);
         iack_i = ($urandom_range(0, 9) == 0);
         op = $urandom_range(0, 9);
         a  = addr_tab[$urandom_range(0, 9)];
         w  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         d  = (a == A_CLAIM) ? 32'($urandom_range(0, 4)) : $urandom;
         if (op < 2) step(1'b0, 4'h0, 24'h0, 32'h0);
         else        step(1'b1, w, a, d);
      end

      irq_i = '0;
      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rs5_plic.md
# rs5_plic

Platform-level interrupt controller for the RS5 SoC, mapped as a 24-bit-addressed peripheral on the core's data bus. It collects `i_cnt` level-sensitive external requests, applies per-source priority, enable and a global threshold, and drives the core's machine external interrupt line. The core claims and completes sources through memory-mapped registers. It serves a single context: hart 0, M-mode.

## Interface
- `i_cnt`, default 1: number of interrupt sources, IDs 1..i_cnt; legal range 1..31. ID 0 means "no interrupt".
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `en_i` input 1: bus access strobe for this cycle.
- `we_i` input 4: byte write enables. Zero means read; nonzero means write.
- `addr_i` input 24: byte address of a word register (bits [1:0] ignored).
- `data_i` input 32: write data.
- `data_o` output 32: read data, registered.
- `irq_i` input [i_cnt:1]: level interrupt requests from peripherals.
- `iack_i` input 1: one-cycle interrupt-taken pulse from the core.
- `iack_o` output [i_cnt:1]: one-cycle claim acknowledge per source, sent to the peripheral.
- `irq_o` output 1: machine external interrupt request to the core.

## Operation
- Register map; all unmapped addresses read 0 and ignore writes:
  - Priority[k] at 0x000000 + 4·k, for k = 1..i_cnt. 3 bits wide, in data[2:0]. Read/write.
  - Pending at 0x001000. Bit k is source k; bit 0 reads 0. Read-only.
  - Enable at 0x002000. Bit k enables source k; bit 0 is hardwired to 0. Read/write.
  - Threshold at 0x200000. 3 bits. Read/write.
  - Claim/complete at 0x200004. A read claims; a write completes.
- Writes honour byte enables, so only the bytes selected by `we_i` are updated.
- Gateway, per source:
  - `pending[k]` is set when `irq_i[k]`=1 and `inflight[k]`=0.
  - Claiming k clears `pending[k]` and sets `inflight[k]`.
  - A complete write of value k clears `inflight[k]`.
  - A complete with ID 0, an ID greater than `i_cnt`, or an ID not in flight is ignored.
- Arbitration:
  - `max_id` is the pending and enabled source with the highest priority.
  - Ties go to the lowest ID.
  - Priority 0 never wins.
  - If no source qualifies, `max_id` = 0.
  - `irq_o` = 1 when `max_id` != 0 and priority[`max_id`] > threshold (strictly greater).
- Snapshot:
  - `iack_i`=1 latches `snap_id` <= `max_id` and sets `snap_valid`.
  - While `snap_valid`=1, `irq_o` is forced to 0.
- Claim read:
  - Returns `snap_id` if `snap_valid`=1, otherwise `max_id`.
  - Clears `snap_valid`.
  - For a nonzero returned ID k, applies the gateway claim actions for k and pulses `iack_o[k]` for one cycle.
  - A claim that returns 0 has no side effects beyond clearing `snap_valid`.
- Other reads return the register value, zero-extended to 32 bits.

## Timing
- Reset:
  - Outputs: `data_o`=0, `irq_o`=0, `iack_o`=0.
  - State: all priorities, enables, threshold, pending, inflight, `snap_id` and `snap_valid` = 0.
- Read latency is one cycle: `data_o` is valid in the cycle after `en_i`=1 with `we_i`=0, and holds its value until the next read.
- Writes take effect at the clock edge of the access.
- `irq_i` is sampled on each edge; `pending` is visible the following cycle.
- `irq_o` is registered and reflects the pending, enable, priority, threshold and snapshot state of the previous cycle. From `irq_i` rising to `irq_o`=1 takes 2 cycles.
- `iack_o[k]` is high in exactly the cycle after the claim read, the same cycle `data_o` shows k.
- Claim read and `iack_i` in the same cycle: the read uses the state before the edge. `snap_valid` ends cleared and the new snapshot is discarded.
- A source that is in flight and has `irq_i` still high does not re-pend until complete. It re-pends on the edge after the complete if `irq_i` is still 1.
- Asynchronous reset asserted mid-operation clears everything immediately, including in-flight claims.

## Test plan
- Reset → `irq_o`=0, `data_o`=0, and reads of pending, enable and claim return 0.
- Setup: priority[1]=3, enable=0x2, threshold=0. Raise `irq_i[1]`. → pending reads 0x2 and `irq_o`=1 within 2 cycles. Then a claim read → `data_o`=1, `iack_o[1]` pulses once, pending=0, and `irq_o` falls.
- Threshold=3 with priority[1]=3 → `irq_o` stays 0. Set threshold=2 → `irq_o`=1.
- With `i_cnt`=3, priority[2]=5, priority[3]=5, all enabled, both sources raised → claim returns 2. Complete 2 → next claim returns 3.
- Pulse `iack_i` → `irq_o` drops. Raise a higher-priority source afterwards → claim still returns the snapshot ID.
- Claimed source with `irq_i` held high → no re-pend. Write complete with the wrong ID → still no re-pend. Write complete with the correct ID → re-pends and `irq_o`=1.
